// File: rtl/ppu_pkg.sv
// Shared types for the PPU write scheduler: region codes, control bits and queue entries.
package ppu_pkg;

  typedef enum logic [2:0] {
    REG_TB   = 3'd0,
    REG_TG   = 3'd1,
    REG_SG   = 3'd2,
    REG_CP   = 3'd3,
    REG_OAM  = 3'd4,
    REG_CTRL = 3'd5
  } region_e;

  localparam int unsigned NUM_MEMS     = 5;
  localparam int unsigned CTRL_IRQ_EN  = 0;
  localparam int unsigned CTRL_IRQ_ACK = 1;
  localparam int unsigned CTRL_OVF_CLR = 2;

  typedef struct packed {
    region_e     region;
    logic [8:0]  offset;
    logic [31:0] data;
  } wr_entry_t;

  // One-hot memory select in render_busy / mem_we bit order; non-memory codes give zero.
  function automatic logic [NUM_MEMS-1:0] region_onehot(input region_e r);
    logic [NUM_MEMS-1:0] oh;
    oh = '0;
    case (r)
      REG_TB:  oh = 5'b00001;
      REG_TG:  oh = 5'b00010;
      REG_SG:  oh = 5'b00100;
      REG_CP:  oh = 5'b01000;
      REG_OAM: oh = 5'b10000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ppu_wr_fifo.sv
// Synchronous write-queue FIFO with registered full/empty; push while full is taken when a pop coincides.
module ppu_wr_fifo
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  wr_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (do_pop && !do_push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/ppu_write_scheduler.sv
// Queues CPU writes and retires them to PPU memories when the renderer is not using them; owns ctrl reg and vblank irq.
// Optional feature macro: PPU_VBLANK_DRAIN_EN (TB/TG/SG entries retire only during vblank).
module ppu_write_scheduler
  import ppu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] write_data,
  input  logic [11:0] address,
  input  logic        write,
  input  logic        chipselect,
  input  logic        vblank,
  input  logic [4:0]  render_busy,
  output logic [4:0]  mem_we,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        irq,
  output logic        fifo_full,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_e;

  state_e    state;
  region_e   region_in;
  wr_entry_t push_entry;
  wr_entry_t head;
  logic [NUM_MEMS-1:0] head_oh;
  logic      fifo_empty;
  logic      wr_acc;
  logic      push_req;
  logic      ctrl_wr;
  logic      gate_open;
  logic      can_issue;
  logic      dropped;
  logic      vblank_q;
  logic      vblank_rise;
  logic      irq_en;

  always_comb begin
    region_in  = region_e'(address[11:9]);
    wr_acc     = write && chipselect;
    push_req   = wr_acc && (address[11:9] <= 3'd4);
    ctrl_wr    = wr_acc && (region_in == REG_CTRL);
    push_entry = '{region: region_in, offset: address[8:0], data: write_data};
    head_oh    = region_onehot(head.region);
`ifdef PPU_VBLANK_DRAIN_EN
    gate_open  = (head.region inside {REG_TB, REG_TG, REG_SG}) ? vblank : 1'b1;
`else
    gate_open  = 1'b1;
`endif
    can_issue   = !fifo_empty && gate_open && ((head_oh & render_busy) == '0);
    // A pop in the same cycle frees a slot, so only a push without a pop is dropped.
    dropped     = push_req && fifo_full && !can_issue;
    vblank_rise = vblank && !vblank_q;
  end

  ppu_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (push_entry),
    .pop   (can_issue),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      irq       <= 1'b0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      vblank_q  <= 1'b0;
    end else begin
      vblank_q <= vblank;
      mem_we   <= '0;
      if (can_issue) begin
        mem_we    <= head_oh;
        mem_addr  <= head.offset;
        mem_wdata <= head.data;
      end

      case (state)
        IDLE:    if (!fifo_empty) state <= can_issue ? ISSUE : WAIT;
        WAIT:    if (can_issue) state <= ISSUE;
        ISSUE: begin
          if (fifo_empty)     state <= IDLE;
          else if (can_issue) state <= ISSUE;
          else                state <= WAIT;
        end
        default: state <= IDLE;
      endcase

      if (ctrl_wr)
        irq_en <= write_data[CTRL_IRQ_EN];

      // Rising-edge set takes priority over a same-cycle acknowledge.
      if (vblank_rise && irq_en)
        irq <= 1'b1;
      else if (ctrl_wr && write_data[CTRL_IRQ_ACK])
        irq <= 1'b0;

      if (dropped)
        overflow <= 1'b1;
      else if (ctrl_wr && write_data[CTRL_OVF_CLR])
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_write_scheduler.sv
// Directed self-checking bench for ppu_write_scheduler.
module tb_ppu_write_scheduler;

  logic        clk;
  logic        reset;
  logic [31:0] write_data;
  logic [11:0] address;
  logic        write;
  logic        chipselect;
  logic        vblank;
  logic [4:0]  render_busy;
  logic [4:0]  mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        irq;
  logic        fifo_full;
  logic        overflow;

  int unsigned n_cmp;
  int unsigned n_bad;

  ppu_write_scheduler #(.FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .write_data  (write_data),
    .address     (address),
    .write       (write),
    .chipselect  (chipselect),
    .vblank      (vblank),
    .render_busy (render_busy),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .irq         (irq),
    .fifo_full   (fifo_full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bus write for a single cycle; returns 1 time unit after the accepting edge.
  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    address    = a;
    write_data = d;
    write      = 1'b1;
    chipselect = 1'b1;
    tick();
    write      = 1'b0;
    chipselect = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    write_data = '0;
    address = '0;
    write = 1'b0;
    chipselect = 1'b0;
    vblank = 1'b0;
    render_busy = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_mem_we",   64'(mem_we),    64'h0);
    check("rst_mem_addr", 64'(mem_addr),  64'h0);
    check("rst_wdata",    64'(mem_wdata), 64'h0);
    check("rst_irq",      64'(irq),       64'h0);
    check("rst_full",     64'(fifo_full), 64'h0);
    check("rst_ovf",      64'(overflow),  64'h0);

    // Single TB write, target free: mem_we in N+2
    bus_write(12'h00A, 32'h1234);
    check("single_n1_we", 64'(mem_we), 64'h0);
    tick();
    check("single_we",    64'(mem_we),    64'h01);
    check("single_addr",  64'(mem_addr),  64'h00A);
    check("single_data",  64'(mem_wdata), 64'h1234);
    tick();
    check("single_pulse", 64'(mem_we), 64'h0);

    // Ignored region 6: no push, no flag change
    bus_write(12'hC00, 32'hDEAD);
    tick();
    check("ign_we",  64'(mem_we),   64'h0);
    check("ign_ovf", 64'(overflow), 64'h0);

    // OAM write blocked by render, TB write queued behind it
    render_busy = 5'b10000;
    bus_write(12'h805, 32'hAAAA_0005);
    bus_write(12'h003, 32'hBBBB_0003);
    begin
      logic [4:0] seen;
      seen = '0;
      for (int i = 0; i < 8; i++) begin
        seen |= mem_we;
        tick();
      end
      seen |= mem_we;
      check("oam_blocked", 64'(seen), 64'h0);
    end
    render_busy = 5'b00000;
    tick();
    check("oam_we",    64'(mem_we),    64'h10);
    check("oam_addr",  64'(mem_addr),  64'h005);
    check("oam_data",  64'(mem_wdata), 64'hAAAA_0005);
    tick();
    check("behind_we",   64'(mem_we),   64'h01);
    check("behind_addr", 64'(mem_addr), 64'h003);
    tick();
    check("oam_idle", 64'(mem_we), 64'h0);

    // Overflow: 9 writes while everything busy
    render_busy = 5'b11111;
    for (int i = 0; i < 8; i++)
      bus_write(12'h010 + 12'(i), 32'h100 + 32'(i));
    check("full_after8", 64'(fifo_full), 64'h1);
    check("ovf_before9", 64'(overflow),  64'h0);
    bus_write(12'h018, 32'h108);
    check("ovf_after9",  64'(overflow),  64'h1);
    check("full_after9", 64'(fifo_full), 64'h1);
    bus_write(12'hA00, 32'h4);
    check("ovf_clear",   64'(overflow),  64'h0);

    // Full FIFO: pop and push in the same cycle; new entry retires last
    render_busy = 5'b11110;
    bus_write(12'h020, 32'hABCD);
    check("pp_ovf",  64'(overflow),  64'h0);
    check("pp_full", 64'(fifo_full), 64'h1);
    begin
      int unsigned bad_seq;
      bad_seq = 0;
      for (int i = 0; i < 9; i++) begin
        logic [8:0]  ea;
        logic [31:0] ed;
        ea = (i < 8) ? 9'h010 + 9'(i) : 9'h020;
        ed = (i < 8) ? 32'h100 + 32'(i) : 32'hABCD;
        if (mem_we !== 5'b00001 || mem_addr !== ea || mem_wdata !== ed)
          bad_seq++;
        if (i < 8) tick();
      end
      check("pp_order", 64'(bad_seq), 64'h0);
    end
    check("pp_last_addr", 64'(mem_addr), 64'h020);
    tick();
    check("pp_drained_we",   64'(mem_we),    64'h0);
    check("pp_drained_full", 64'(fifo_full), 64'h0);
    render_busy = 5'b00000;

    // irq: enable, edge, ack, edge+ack same cycle
    bus_write(12'hA00, 32'h1);
    check("irq_pre", 64'(irq), 64'h0);
    vblank = 1'b1;
    tick();
    check("irq_set", 64'(irq), 64'h1);
    bus_write(12'hA00, 32'h3);
    check("irq_ack", 64'(irq), 64'h0);
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    bus_write(12'hA00, 32'h2);
    check("irq_set_wins", 64'(irq), 64'h1);
    vblank = 1'b0;
    tick();
    check("irq_en_clr_keeps", 64'(irq), 64'h1);
    bus_write(12'hA00, 32'h2);
    check("irq_ack2", 64'(irq), 64'h0);
    vblank = 1'b1;
    tick();
    tick();
    check("irq_disabled", 64'(irq), 64'h0);
    vblank = 1'b0;
    tick();

    // Reset with 5 queued entries
    render_busy = 5'b11111;
    for (int i = 0; i < 5; i++)
      bus_write(12'h030 + 12'(i), 32'h200 + 32'(i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    render_busy = 5'b00000;
    begin
      logic [4:0] seen;
      seen = '0;
      for (int i = 0; i < 5; i++) begin
        seen |= mem_we;
        tick();
      end
      check("rst_mid_we", 64'(seen), 64'h0);
    end
    check("rst_mid_addr", 64'(mem_addr),  64'h0);
    check("rst_mid_data", 64'(mem_wdata), 64'h0);
    check("rst_mid_full", 64'(fifo_full), 64'h0);
    check("rst_mid_ovf",  64'(overflow),  64'h0);
    check("rst_mid_irq",  64'(irq),       64'h0);

    // TG write while vblank low
    vblank = 1'b0;
    bus_write(12'h207, 32'h7777);
`ifdef PPU_VBLANK_DRAIN_EN
    begin
      logic [4:0] seen;
      seen = '0;
      for (int i = 0; i < 3; i++) begin
        tick();
        seen |= mem_we;
      end
      check("drain_wait", 64'(seen), 64'h0);
    end
    vblank = 1'b1;
    tick();
    check("drain_we",   64'(mem_we),   64'h02);
    check("drain_addr", 64'(mem_addr), 64'h007);
    vblank = 1'b0;
`else
    tick();
    check("tg_we",   64'(mem_we),    64'h02);
    check("tg_addr", 64'(mem_addr),  64'h007);
    check("tg_data", 64'(mem_wdata), 64'h7777);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
